// File: rtl/data_island_packet_scheduler.sv
// HDMI data-island slot scheduler: fixed-priority grant of ACR/sample/InfoFrame/null per slot.
// Optional SPD InfoFrame support is enabled by defining HDMI_SPD_PACKET_EN.
module data_island_packet_scheduler #(
  parameter int PACKET_CYCLES    = 32,
  parameter int SAMPLE_BURST_MAX = 4,
  parameter int INFOFRAME_PERIOD = 1
) (
  input  logic       clk_pixel_i,
  input  logic       reset_n_i,
  input  logic       slot_start_i,
  input  logic       frame_start_i,
  input  logic       acr_wrap_i,
  input  logic       sample_avail_i,
  output logic       sample_ack_o,
  output logic       pkt_valid_o,
  output logic [7:0] pkt_type_o,
  output logic       acr_overrun_o
);
  localparam int SCW = $clog2(PACKET_CYCLES);
  localparam int BCW = $clog2(SAMPLE_BURST_MAX + 1);
  localparam int FCW = (INFOFRAME_PERIOD > 1) ? $clog2(INFOFRAME_PERIOD) : 1;

  localparam logic [7:0] TYPE_NULL   = 8'h00;
  localparam logic [7:0] TYPE_ACR    = 8'h01;
  localparam logic [7:0] TYPE_SAMPLE = 8'h02;
  localparam logic [7:0] TYPE_AVI    = 8'h82;
  localparam logic [7:0] TYPE_AIF    = 8'h84;
`ifdef HDMI_SPD_PACKET_EN
  localparam logic [7:0] TYPE_SPD    = 8'h83;
`endif

  // state | meaning
  // IDLE  | no slot in flight, a slot_start is granted
  // SEND  | packet on the wire, slot_cnt counts its pixel clocks
  typedef enum logic {IDLE, SEND} state_t;

  state_t           state_q, state_d;
  logic [SCW-1:0]   slot_cnt_q, slot_cnt_d;
  logic [BCW-1:0]   burst_cnt_q, burst_cnt_d;
  logic [FCW-1:0]   frame_cnt_q, frame_cnt_d;
  logic             acr_wrap_q, acr_armed_q;
  logic             acr_pend_q, acr_pend_d;
  logic             avi_pend_q, avi_pend_d;
  logic             aif_pend_q, aif_pend_d;
`ifdef HDMI_SPD_PACKET_EN
  logic             spd_pend_q, spd_pend_d;
`endif
  logic             acr_overrun_q, acr_overrun_d;
  logic             sample_ack_q, sample_ack_d;
  logic [7:0]       pkt_type_q, pkt_type_d;
  logic             acr_evt, rearm, slot_last, grant, ifr_pend, sample_ok;

  // The armed flag masks the first cycle after reset while acr_wrap_q picks up the live level.
  assign acr_evt   = acr_armed_q && (acr_wrap_i != acr_wrap_q);
  assign rearm     = frame_start_i && (frame_cnt_q == FCW'(INFOFRAME_PERIOD - 1));
  assign slot_last = (state_q == SEND) && (slot_cnt_q == SCW'(PACKET_CYCLES - 1));
  assign grant     = slot_start_i && ((state_q == IDLE) || slot_last);
`ifdef HDMI_SPD_PACKET_EN
  assign ifr_pend  = avi_pend_q || aif_pend_q || spd_pend_q;
`else
  assign ifr_pend  = avi_pend_q || aif_pend_q;
`endif
  assign sample_ok = sample_avail_i && !((burst_cnt_q == BCW'(SAMPLE_BURST_MAX)) && ifr_pend);

  always_comb begin
    state_d       = state_q;
    slot_cnt_d    = slot_cnt_q;
    burst_cnt_d   = burst_cnt_q;
    frame_cnt_d   = frame_cnt_q;
    acr_pend_d    = acr_pend_q;
    avi_pend_d    = avi_pend_q;
    aif_pend_d    = aif_pend_q;
`ifdef HDMI_SPD_PACKET_EN
    spd_pend_d    = spd_pend_q;
`endif
    acr_overrun_d = acr_overrun_q;
    sample_ack_d  = 1'b0;
    pkt_type_d    = pkt_type_q;

    if (frame_start_i) begin
      frame_cnt_d = rearm ? '0 : frame_cnt_q + FCW'(1);
    end

    case (state_q)
      IDLE: if (grant) begin
        state_d    = SEND;
        slot_cnt_d = '0;
      end
      SEND: begin
        if (slot_last) begin
          state_d    = grant ? SEND : IDLE;
          slot_cnt_d = '0;
        end else begin
          slot_cnt_d = slot_cnt_q + SCW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (grant) begin
      burst_cnt_d = '0;
      if (acr_pend_q) begin
        pkt_type_d = TYPE_ACR;
        acr_pend_d = 1'b0;
      end else if (sample_ok) begin
        pkt_type_d   = TYPE_SAMPLE;
        sample_ack_d = 1'b1;
        burst_cnt_d  = (burst_cnt_q == BCW'(SAMPLE_BURST_MAX)) ? burst_cnt_q
                                                               : burst_cnt_q + BCW'(1);
      end else if (avi_pend_q) begin
        pkt_type_d = TYPE_AVI;
        avi_pend_d = 1'b0;
      end else if (aif_pend_q) begin
        pkt_type_d = TYPE_AIF;
        aif_pend_d = 1'b0;
`ifdef HDMI_SPD_PACKET_EN
      end else if (spd_pend_q) begin
        pkt_type_d = TYPE_SPD;
        spd_pend_d = 1'b0;
`endif
      end else begin
        pkt_type_d = TYPE_NULL;
      end
    end

    // Set events land after the grant clears so a coincident set wins.
    if (acr_evt) begin
      acr_pend_d = 1'b1;
      if (acr_pend_q && !grant) acr_overrun_d = 1'b1;
    end
    if (rearm) begin
      avi_pend_d = 1'b1;
      aif_pend_d = 1'b1;
`ifdef HDMI_SPD_PACKET_EN
      spd_pend_d = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk_pixel_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q       <= IDLE;
      slot_cnt_q    <= '0;
      burst_cnt_q   <= '0;
      frame_cnt_q   <= '0;
      acr_wrap_q    <= 1'b0;
      acr_armed_q   <= 1'b0;
      acr_pend_q    <= 1'b0;
      avi_pend_q    <= 1'b1;
      aif_pend_q    <= 1'b1;
`ifdef HDMI_SPD_PACKET_EN
      spd_pend_q    <= 1'b1;
`endif
      acr_overrun_q <= 1'b0;
      sample_ack_q  <= 1'b0;
      pkt_type_q    <= TYPE_NULL;
    end else begin
      state_q       <= state_d;
      slot_cnt_q    <= slot_cnt_d;
      burst_cnt_q   <= burst_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      acr_wrap_q    <= acr_wrap_i;
      acr_armed_q   <= 1'b1;
      acr_pend_q    <= acr_pend_d;
      avi_pend_q    <= avi_pend_d;
      aif_pend_q    <= aif_pend_d;
`ifdef HDMI_SPD_PACKET_EN
      spd_pend_q    <= spd_pend_d;
`endif
      acr_overrun_q <= acr_overrun_d;
      sample_ack_q  <= sample_ack_d;
      pkt_type_q    <= pkt_type_d;
    end
  end

  assign pkt_valid_o   = (state_q == SEND);
  assign pkt_type_o    = pkt_type_q;
  assign sample_ack_o  = sample_ack_q;
  assign acr_overrun_o = acr_overrun_q;

endmodule
